pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage ARM pipeline. It drives the enable and bubble (NOP-insert) controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and inserts one bubble.
- Squashes wrong-path instructions on a taken branch.
- Freezes the whole pipeline while a multi-cycle data-memory access waits on a ready handshake, with a bounded timeout.
- Keeps a saturating stall-cycle counter for performance analysis.

Parameters:
MAX_WAIT, 15, maximum MEM_WAIT cycles tolerated before declaring a timeout (1..255)
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
id_rn_addr  in  4  ID-stage first source register
id_rm_addr  in  4  ID-stage second source register
id_rn_used  in  1  ID instruction actually reads Rn
id_rm_used  in  1  ID instruction actually reads Rm
ex_mem_read  in  1  EX-stage instruction is a load
ex_reg_write  in  1  EX-stage instruction writes a register
ex_dest_addr  in  4  EX-stage destination register
branch_taken  in  1  taken branch resolved this cycle
dmem_req  in  1  MEM stage has an active data-memory access (mem_enable)
dmem_ready  in  1  data memory completes the access this cycle
pc_enable  out  1  PC may load its next value
if_id_enable  out  1  IF/ID register load enable
if_id_flush  out  1  IF/ID register clears to NOP
id_ex_enable  out  1  ID/EX register load enable
id_ex_bubble  out  1  ID/EX control fields clear to 0 (NOP)
ex_mem_enable  out  1  EX/MEM register load enable
mem_wb_enable  out  1  MEM/WB register load enable
mem_wb_bubble  out  1  MEM/WB control fields clear to 0 (no writeback)
mem_timeout  out  1  sticky error flag
stall_cycles  out  CNT_W  saturating count of cycles with pc_enable=0

Behaviour:
- FSM states: RUN, MEM_WAIT, HALT. All control outputs are combinational (Mealy) from the state and the current inputs, giving zero-cycle response. The state, wait_cnt, stall_cycles and mem_timeout are registered.
- While reset=0 (asynchronous):
  - State goes to RUN; wait_cnt=0; stall_cycles=0; mem_timeout=0.
  - Outputs are forced: all enables 0, if_id_flush=1, id_ex_bubble=1, mem_wb_bubble=1.
- Default in RUN: all enables 1, flush and bubble outputs 0.
- Load-use hazard (hazard_detect, combinational): ex_mem_read & ex_reg_write & ((id_rn_used & id_rn_addr==ex_dest_addr) | (id_rm_used & id_rm_addr==ex_dest_addr)).
- Priority within RUN, highest first:
  1. dmem_req & !dmem_ready:
     - pc/if_id/id_ex/ex_mem enables all 0, mem_wb_bubble=1.
     - wait_cnt<=1; next state MEM_WAIT.
  2. branch_taken:
     - if_id_flush=1, id_ex_bubble=1, pc_enable=1.
     - A simultaneous load-use hazard is ignored, because the dependent instruction is squashed.
  3. Load-use hazard:
     - pc_enable=0, if_id_enable=0, id_ex_bubble=1.
     - Exactly one bubble is inserted. On the next cycle the load is in MEM and the hazard clears naturally.
- dmem_req & dmem_ready in RUN (single-cycle access): no stall.
- MEM_WAIT:
  - If dmem_ready=1: outputs as RUN default; next state RUN; wait_cnt<=0.
  - Else, if wait_cnt==MAX_WAIT: next state HALT; mem_timeout<=1.
  - Else: freeze as in priority 1; wait_cnt<=wait_cnt+1.
  - branch_taken and the hazard inputs are ignored in MEM_WAIT. The frozen stages re-present them after release.
- HALT:
  - Outputs are frozen as in MEM_WAIT.
  - mem_timeout stays 1 and the FSM stays in HALT until reset; dmem_ready is ignored.
- stall_cycles:
  - Increments in every cycle with pc_enable=0 and reset=1.
  - Saturates at 2^CNT_W-1 and never wraps.
- Reset asserted mid-MEM_WAIT aborts the wait immediately. The next state after release is RUN with clean pipeline controls.

Decomposition:
- pipe_ctrl_pkg holds:
  - State encoding: RUN=2'b00, MEM_WAIT=2'b01, HALT=2'b10.
  - REG_ADDR_W=4.
  - Default MAX_WAIT.
- One combinational sub-module, hazard_detect: source/destination compare producing load_use.

Test Plan:
- Reset release with no requests -> first cycle: all enables 1, bubbles 0, stall_cycles=0.
- ex_mem_read=1, ex_reg_write=1, ex_dest_addr=3, id_rn_addr=3, id_rn_used=1 -> exactly one cycle with pc_enable=0, if_id_enable=0, id_ex_bubble=1; stall_cycles=1 afterwards.
- Same hazard plus branch_taken=1 in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_enable=1; stall_cycles unchanged.
- dmem_req=1 with dmem_ready low for 3 cycles, then high:
  - Freeze and mem_wb_bubble=1 for 3 cycles.
  - Release in the ready cycle.
  - stall_cycles=3, mem_timeout=0.
- MAX_WAIT=4 with dmem_ready held low -> state HALT and mem_timeout=1 after 5 frozen cycles; later dmem_ready=1 changes nothing; a reset pulse clears everything.
- Reset asserted during the 2nd MEM_WAIT cycle -> outputs forced to reset values the same cycle; RUN state after release; stall_cycles=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W       = 4;
  localparam int MAX_WAIT_DEFAULT = 15;
  // Wide enough for the largest legal MAX_WAIT (255).
  localparam int WAIT_CNT_W       = 8;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } pipe_state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID-stage sources and the EX-stage load.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rn_addr,
  input  logic [REG_ADDR_W-1:0] id_rm_addr,
  input  logic                  id_rn_used,
  input  logic                  id_rm_used,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_dest_addr,
  output logic                  load_use
);

  logic rn_match;
  logic rm_match;

  // A source only matters when the ID instruction really reads it.
  always_comb begin
    rn_match = id_rn_used && (id_rn_addr == ex_dest_addr);
    rm_match = id_rm_used && (id_rm_addr == ex_dest_addr);
    load_use = ex_mem_read && ex_reg_write && (rn_match || rm_match);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch
// squash, data-memory wait freeze with timeout, and a stall-cycle counter.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   RUN      | normal flow; hazard bubble / branch squash applied here
//   MEM_WAIT | whole pipe frozen until dmem_ready or MAX_WAIT reached
//   HALT     | memory timed out; pipe frozen until reset
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rn_addr,
  input  logic [REG_ADDR_W-1:0] id_rm_addr,
  input  logic                  id_rn_used,
  input  logic                  id_rm_used,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_dest_addr,
  input  logic                  branch_taken,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_enable,
  output logic                  if_id_enable,
  output logic                  if_id_flush,
  output logic                  id_ex_enable,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_enable,
  output logic                  mem_wb_enable,
  output logic                  mem_wb_bubble,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles
);

  pipe_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]      stall_cycles_q, stall_cycles_d;
  logic                  mem_timeout_q, mem_timeout_d;
  logic                  load_use;
  logic                  freeze;

  hazard_detect u_hazard_detect (
    .id_rn_addr   (id_rn_addr),
    .id_rm_addr   (id_rm_addr),
    .id_rn_used   (id_rn_used),
    .id_rm_used   (id_rm_used),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .ex_dest_addr (ex_dest_addr),
    .load_use     (load_use)
  );

  // Next state and Mealy pipeline controls; reset overrides everything.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    freeze        = 1'b0;
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_enable  = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_enable = 1'b1;
    mem_wb_enable = 1'b1;
    mem_wb_bubble = 1'b0;

    case (state_q)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          freeze     = 1'b1;
          wait_cnt_d = WAIT_CNT_W'(1);
          state_d    = MEM_WAIT;
        end else if (branch_taken) begin
          // The dependent instruction of any coincident hazard is squashed.
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use) begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt_q == WAIT_CNT_W'(MAX_WAIT)) begin
            state_d       = HALT;
            mem_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
          end
        end
      end
      HALT: begin
        freeze = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (freeze) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_bubble = 1'b1;
    end

    if (!reset) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_enable  = 1'b0;
      id_ex_bubble  = 1'b1;
      ex_mem_enable = 1'b0;
      mem_wb_enable = 1'b0;
      mem_wb_bubble = 1'b1;
    end
  end

  // Count stalled cycles, holding at all-ones instead of wrapping.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_enable && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  // State, wait counter, stall counter and sticky timeout registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
      mem_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      mem_timeout_q  <= mem_timeout_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios then random traffic,
// each cycle's expectation produced by a behavioural model and queued.
module tb_pipeline_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int MW = 4;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    id_rn_addr = '0, id_rm_addr = '0, ex_dest_addr = '0;
  logic          id_rn_used = 1'b0, id_rm_used = 1'b0;
  logic          ex_mem_read = 1'b0, ex_reg_write = 1'b0;
  logic          branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic          pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_bubble;
  logic          ex_mem_enable, mem_wb_enable, mem_wb_bubble, mem_timeout;
  logic [CW-1:0] stall_cycles;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rn_addr(id_rn_addr), .id_rm_addr(id_rm_addr),
    .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_dest_addr(ex_dest_addr), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
    .id_ex_enable(id_ex_enable), .id_ex_bubble(id_ex_bubble),
    .ex_mem_enable(ex_mem_enable), .mem_wb_enable(mem_wb_enable),
    .mem_wb_bubble(mem_wb_bubble), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic [3:0] rn, rm;
    logic       rn_used, rm_used, mem_read, reg_write;
    logic [3:0] dest;
    logic       br, req, rdy;
  } stim_t;

  typedef struct {
    int            id;
    logic [7:0]    ctl;
    logic          to;
    logic [CW-1:0] stall;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model: mode 0 flowing, 1 waiting on memory, 2 timed out.
  int   m_mode   = 0;
  int   m_frozen = 0;
  int   m_stall  = 0;
  bit   m_to     = 0;

  task automatic do_cycle(input logic rst, input stim_t s);
    exp_t e;
    bit pc, ifen, fl, iden, bub, exen, mwen, mwbub, hz, frz;
    @(posedge clk);
    #1;
    reset        = rst;
    id_rn_addr   = s.rn;
    id_rm_addr   = s.rm;
    id_rn_used   = s.rn_used;
    id_rm_used   = s.rm_used;
    ex_mem_read  = s.mem_read;
    ex_reg_write = s.reg_write;
    ex_dest_addr = s.dest;
    branch_taken = s.br;
    dmem_req     = s.req;
    dmem_ready   = s.rdy;
    cyc++;
    e.id = cyc;
    if (!rst) begin
      m_mode   = 0;
      m_frozen = 0;
      m_stall  = 0;
      m_to     = 0;
      e.ctl    = 8'b0010_1001;
      e.to     = 1'b0;
      e.stall  = '0;
    end else begin
      e.to    = m_to;
      e.stall = CW'(m_stall);
      hz = s.mem_read && s.reg_write &&
           ((s.rn_used && s.rn == s.dest) || (s.rm_used && s.rm == s.dest));
      pc = 1; ifen = 1; fl = 0; iden = 1; bub = 0; exen = 1; mwen = 1; mwbub = 0; frz = 0;
      case (m_mode)
        0: begin
          if (s.req && !s.rdy) begin
            frz = 1; m_frozen = 1; m_mode = 1;
          end else if (s.br) begin
            fl = 1; bub = 1;
          end else if (hz) begin
            pc = 0; ifen = 0; bub = 1;
          end
        end
        1: begin
          if (s.rdy) begin
            m_mode = 0;
          end else begin
            frz = 1;
            m_frozen++;
            if (m_frozen == MW + 1) begin
              m_mode = 2;
              m_to   = 1;
            end
          end
        end
        default: frz = 1;
      endcase
      if (frz) begin
        pc = 0; ifen = 0; iden = 0; exen = 0; mwbub = 1;
      end
      if (!pc && m_stall < (1 << CW) - 1) m_stall++;
      e.ctl = {pc, ifen, fl, iden, bub, exen, mwen, mwbub};
    end
    sb.push_back(e);
  endtask

  function automatic stim_t rnd_stim();
    stim_t s;
    s.rn        = 4'($urandom_range(0, 3));
    s.rm        = 4'($urandom_range(0, 3));
    s.dest      = 4'($urandom_range(0, 3));
    s.rn_used   = 1'($urandom_range(0, 1));
    s.rm_used   = 1'($urandom_range(0, 1));
    s.mem_read  = 1'($urandom_range(0, 1));
    s.reg_write = ($urandom_range(0, 3) != 0);
    s.br        = ($urandom_range(0, 5) == 0);
    s.req       = ($urandom_range(0, 3) == 0);
    s.rdy       = 1'($urandom_range(0, 1));
    return s;
  endfunction

  // Monitor: every cycle presents outputs; compare against the queued expectation.
  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [7:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_bubble,
             ex_mem_enable, mem_wb_enable, mem_wb_bubble};
      n_tests++;
      if (act !== e.ctl || mem_timeout !== e.to || stall_cycles !== e.stall) begin
        n_fail++;
        $display("FAIL cyc%0d outputs: got ctl=%b to=%b stall=%0d, expected ctl=%b to=%b stall=%0d",
                 e.id, act, mem_timeout, stall_cycles, e.ctl, e.to, e.stall);
      end
    end
  end

  initial begin
    stim_t idle, s, w;
    idle = '0;

    // Reset held, then released with no activity.
    repeat (3) do_cycle(1'b0, idle);
    repeat (2) do_cycle(1'b1, idle);

    // Load-use on Rn: one bubble, stall count 1 afterwards.
    s = idle;
    s.mem_read = 1; s.reg_write = 1; s.dest = 4'd3; s.rn = 4'd3; s.rn_used = 1;
    do_cycle(1'b1, s);
    repeat (2) do_cycle(1'b1, idle);

    // Same hazard with a taken branch: squash, no stall.
    s.br = 1;
    do_cycle(1'b1, s);
    do_cycle(1'b1, idle);

    // Load-use on Rm, and a matching address that is not actually read.
    s = idle;
    s.mem_read = 1; s.reg_write = 1; s.dest = 4'd5; s.rm = 4'd5; s.rm_used = 1;
    do_cycle(1'b1, s);
    s.rm_used = 0;
    do_cycle(1'b1, s);
    s.rm_used = 1; s.reg_write = 0;
    do_cycle(1'b1, s);

    // Three-cycle memory wait then release; single-cycle access after.
    w = idle; w.req = 1;
    repeat (3) do_cycle(1'b1, w);
    w.rdy = 1;
    do_cycle(1'b1, w);
    do_cycle(1'b1, w);
    do_cycle(1'b1, idle);

    // Timeout: ready never comes, later ready is ignored, reset recovers.
    w.rdy = 0;
    repeat (7) do_cycle(1'b1, w);
    w.rdy = 1;
    repeat (3) do_cycle(1'b1, w);
    do_cycle(1'b0, idle);
    repeat (2) do_cycle(1'b1, idle);

    // Reset during the memory wait.
    w.rdy = 0;
    repeat (2) do_cycle(1'b1, w);
    do_cycle(1'b0, w);
    repeat (2) do_cycle(1'b1, idle);

    // Long halt drives the stall counter into saturation.
    repeat (80) do_cycle(1'b1, w);
    do_cycle(1'b0, idle);
    do_cycle(1'b1, idle);

    // Random traffic with occasional reset pulses.
    repeat (3000) do_cycle(($urandom_range(0, 49) != 0), rnd_stim());

    @(posedge clk);
    @(posedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
